// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the multiplier time-share scheduler.
// Tag layout travels alongside each operand pair through the core latency.
package mult_share_pkg;

   localparam int DATA_W = 16;
   localparam int PROD_W = 2 * DATA_W;
   localparam int ID_W   = 3;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
      logic            neg;
   } tag_t;

   // Unsigned magnitude; the most negative value maps to 0x8000.
   function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
      return x[DATA_W-1] ? (~x + DATA_W'(1)) : x;
   endfunction

endpackage

// File: rtl/mult_share_arb.sv
// Grant logic for the shared multiplier requesters.
// MULT_SHARE_RR_EN selects round-robin; otherwise lowest index wins.
module mult_share_arb
   import mult_share_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int RID_W = 2
) (
`ifdef MULT_SHARE_RR_EN
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             acc,
`endif
   input  logic             g_en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [RID_W-1:0] win_id
);

`ifdef MULT_SHARE_RR_EN
   logic [RID_W-1:0] ptr;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         ptr <= '0;
      end else if (acc) begin
         ptr <= (int'(win_id) == N_REQ - 1) ? '0 : win_id + 1'b1;
      end
   end
`endif

   always_comb begin : p_pick
      int   idx;
      logic found;
      gnt    = '0;
      win_id = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < N_REQ; k++) begin
`ifdef MULT_SHARE_RR_EN
         idx = (int'(ptr) + k) % N_REQ;
`else
         idx = k;
`endif
         if (g_en && !found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            win_id   = RID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/mult_share_sched.sv
// Time-shares one pipelined unsigned multiplier among N_REQ signed requesters.
// Define MULT_SHARE_RR_EN for round-robin grants (default: fixed priority).
module mult_share_sched
   import mult_share_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int MULT_LAT = 3,
   localparam int RID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    en,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] a_in,
   input  logic [N_REQ*DATA_W-1:0] b_in,
   output logic [N_REQ-1:0]        gnt,
   output logic [DATA_W-1:0]       core_a,
   output logic [DATA_W-1:0]       core_b,
   input  logic [PROD_W-1:0]       core_p,
   output logic [N_REQ-1:0]        res_valid,
   output logic [RID_W-1:0]        res_id,
   output logic [PROD_W-1:0]       res_p,
   output logic                    busy
);

   logic [RID_W-1:0]  win_id;
   logic              acc;
   logic              g_en;
   logic [DATA_W-1:0] a_sel;
   logic [DATA_W-1:0] b_sel;
   tag_t              nxt_tag;
   tag_t              iss_tag;
   tag_t              tag_pipe [MULT_LAT];
   tag_t              ret_tag;

   assign g_en = en & RST_N;
   assign acc  = |(req & gnt);

   mult_share_arb #(
      .N_REQ (N_REQ),
      .RID_W (RID_W)
   ) u_arb (
`ifdef MULT_SHARE_RR_EN
      .CLK    (CLK),
      .RST_N  (RST_N),
      .acc    (acc),
`endif
      .g_en   (g_en),
      .req    (req),
      .gnt    (gnt),
      .win_id (win_id)
   );

   always_comb begin
      a_sel = a_in[int'(win_id)*DATA_W +: DATA_W];
      b_sel = b_in[int'(win_id)*DATA_W +: DATA_W];
   end

   // Zero operands never carry a negative sign into the result.
   always_comb begin
      nxt_tag = '0;
      if (acc) begin
         nxt_tag.valid = 1'b1;
         nxt_tag.id    = ID_W'(win_id);
         nxt_tag.neg   = (a_sel[DATA_W-1] ^ b_sel[DATA_W-1])
                       & (|a_sel) & (|b_sel);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         core_a  <= '0;
         core_b  <= '0;
         iss_tag <= '0;
      end else begin
         core_a  <= acc ? mag(a_sel) : '0;
         core_b  <= acc ? mag(b_sel) : '0;
         iss_tag <= nxt_tag;
      end
   end

   // Tag rides beside the core so it lines up with core_p.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int i = 0; i < MULT_LAT; i++) begin
            tag_pipe[i] <= '0;
         end
      end else begin
         tag_pipe[0] <= iss_tag;
         for (int i = 1; i < MULT_LAT; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   assign ret_tag = tag_pipe[MULT_LAT-1];

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         res_valid <= '0;
         res_id    <= '0;
         res_p     <= '0;
      end else begin
         res_valid <= '0;
         if (ret_tag.valid) begin
            res_valid <= N_REQ'(1) << ret_tag.id;
            res_id    <= RID_W'(ret_tag.id);
            res_p     <= ret_tag.neg ? -core_p : core_p;
         end
      end
   end

   always_comb begin
      busy = iss_tag.valid | (|res_valid);
      for (int i = 0; i < MULT_LAT; i++) begin
         busy = busy | tag_pipe[i].valid;
      end
   end

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched with a queue-based reference model.
// Honours MULT_SHARE_RR_EN to pick the expected grant policy.
module tb_mult_share_sched;

   localparam int N = 4;
`ifdef MULT_SHARE_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  req = '0;
   logic [15:0] av [N];
   logic [15:0] bv [N];
   logic [63:0] a_in;
   logic [63:0] b_in;
   logic [3:0]  gnt;
   logic [15:0] core_a;
   logic [15:0] core_b;
   logic [31:0] core_p;
   logic [3:0]  res_valid;
   logic [1:0]  res_id;
   logic [31:0] res_p;
   logic        busy;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         a_in[i*16 +: 16] = av[i];
         b_in[i*16 +: 16] = bv[i];
      end
   end

   mult_share_sched #(.N_REQ(4), .MULT_LAT(3)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .en        (en),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .gnt       (gnt),
      .core_a    (core_a),
      .core_b    (core_b),
      .core_p    (core_p),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_p     (res_p),
      .busy      (busy)
   );

   // Core stand-in: unsigned product, three register stages, never reset.
   logic [31:0] p1 = '0;
   logic [31:0] p2 = '0;
   logic [31:0] p3 = '0;
   always @(posedge CLK) begin
      p1 <= {16'b0, core_a} * {16'b0, core_b};
      p2 <= p1;
      p3 <= p2;
   end
   assign core_p = p3;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] absv(input logic [15:0] x);
      int s;
      s = int'($signed(x));
      if (s < 0) s = -s;
      return s[15:0];
   endfunction

   typedef struct {
      int          due;
      logic [1:0]  id;
      logic [31:0] p;
   } ent_t;

   ent_t        pend [$];
   int          cyc = 0;
   int          mptr = 0;
   logic [3:0]  m_rv = '0;
   logic [1:0]  m_id = '0;
   logic [31:0] m_p = '0;
   logic [15:0] m_ca = '0;
   logic [15:0] m_cb = '0;
   logic        m_busy = 1'b0;

   // Reference: pick winner by policy, schedule result 4 edges later.
   always @(posedge CLK) begin : model
      int          win;
      logic [3:0]  eg;
      logic signed [31:0] pr;
      cyc++;
      win = -1;
      if (RST_N && en) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = RR ? (mptr + k) % N : k;
            if (win < 0 && req[j]) win = j;
         end
      end
      eg = (win >= 0) ? (4'd1 << win) : 4'd0;
      chk("gnt", {28'b0, gnt}, {28'b0, eg});
      m_rv = '0;
      if (!RST_N) begin
         pend.delete();
         mptr = 0;
         m_id = '0;
         m_p  = '0;
         m_ca = '0;
         m_cb = '0;
      end else begin
         if (pend.size() > 0 && pend[0].due == cyc) begin
            ent_t e;
            e = pend.pop_front();
            m_rv = 4'd1 << e.id;
            m_id = e.id;
            m_p  = e.p;
         end
         if (win >= 0) begin
            pr   = $signed(av[win]) * $signed(bv[win]);
            m_ca = absv(av[win]);
            m_cb = absv(bv[win]);
            pend.push_back('{cyc + 4, 2'(win), pr});
            mptr = (win + 1) % N;
         end else begin
            m_ca = '0;
            m_cb = '0;
         end
      end
      m_busy = (pend.size() > 0) || (m_rv != 0);
   end

   always @(posedge CLK) begin
      #1;
      chk("res_valid", {28'b0, res_valid}, {28'b0, m_rv});
      chk("res_id", {30'b0, res_id}, {30'b0, m_id});
      chk("res_p", res_p, m_p);
      chk("core_a", {16'b0, core_a}, {16'b0, m_ca});
      chk("core_b", {16'b0, core_b}, {16'b0, m_cb});
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
   end

   logic [3:0] rr_seq [8];

   initial begin
      rr_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
      for (int i = 0; i < N; i++) begin
         av[i] = '0;
         bv[i] = '0;
      end
      en  = 1'b1;
      req = 4'b0101;
      @(negedge CLK);
      #1 chk("rst_gnt", {28'b0, gnt}, 32'h0);
      @(negedge CLK);
      RST_N = 1'b1;
      req   = '0;
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_rv", {28'b0, res_valid}, 32'h0);
      chk("rst_p", res_p, 32'h0);

      // 3 * -5
      av[0] = 16'd3;
      bv[0] = 16'hFFFB;
      req   = 4'b0001;
      @(posedge CLK);
      @(negedge CLK);
      req = '0;
      chk("t1_core_a", {16'b0, core_a}, 32'd3);
      chk("t1_core_b", {16'b0, core_b}, 32'd5);
      repeat (4) @(posedge CLK);
      #2;
      chk("t1_rv", {28'b0, res_valid}, 32'h1);
      chk("t1_id", {30'b0, res_id}, 32'h0);
      chk("t1_p", res_p, 32'hFFFFFFF1);
      @(negedge CLK);

      // most negative operands, back to back
      av[2] = 16'h8000;
      bv[2] = 16'h8000;
      req   = 4'b0100;
      @(posedge CLK);
      @(negedge CLK);
      bv[2] = 16'h0001;
      @(posedge CLK);
      @(negedge CLK);
      req = '0;
      repeat (3) @(posedge CLK);
      #2;
      chk("t2_rv", {28'b0, res_valid}, 32'h4);
      chk("t2_id", {30'b0, res_id}, 32'h2);
      chk("t2_p0", res_p, 32'h40000000);
      @(posedge CLK);
      #2;
      chk("t2_p1", res_p, 32'hFFFF8000);
      @(negedge CLK);

      // zero times negative
      av[1] = 16'h0000;
      bv[1] = 16'hFFF9;
      req   = 4'b0010;
      @(posedge CLK);
      @(negedge CLK);
      req = '0;
      repeat (4) @(posedge CLK);
      #2;
      chk("zero_rv", {28'b0, res_valid}, 32'h2);
      chk("zero_p", res_p, 32'h0);
      @(negedge CLK);

      // all requesting, pointer freshly reset
      RST_N = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      for (int i = 0; i < N; i++) begin
         av[i] = 16'(i * 100 + 7);
         bv[i] = 16'(-(i + 3));
      end
      req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1 chk("t3_gnt", {28'b0, gnt},
                {28'b0, RR ? rr_seq[k] : 4'h1});
         @(negedge CLK);
      end
      req = '0;
      repeat (6) @(negedge CLK);

      // two requesters on consecutive edges
      av[1] = 16'd1234;
      bv[1] = 16'hFFFD;
      av[3] = 16'hFF9C;
      bv[3] = 16'd200;
      req   = 4'b0010;
      @(posedge CLK);
      @(negedge CLK);
      req = 4'b1000;
      @(posedge CLK);
      @(negedge CLK);
      req = '0;
      repeat (3) @(posedge CLK);
      #2;
      chk("t4_rv1", {28'b0, res_valid}, 32'h2);
      chk("t4_p1", res_p, 32'hFFFFF18A);
      @(posedge CLK);
      #2;
      chk("t4_rv3", {28'b0, res_valid}, 32'h8);
      chk("t4_p3", res_p, 32'hFFFFB1E0);
      @(posedge CLK);
      #2;
      chk("t4_rv_end", {28'b0, res_valid}, 32'h0);
      @(negedge CLK);

      // reset while an op is in flight
      av[0] = 16'd7;
      bv[0] = 16'd9;
      req   = 4'b0001;
      @(posedge CLK);
      @(negedge CLK);
      req = '0;
      @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b0;
      @(posedge CLK);
      #2;
      chk("t5_busy", {31'b0, busy}, 32'h0);
      chk("t5_rv", {28'b0, res_valid}, 32'h0);
      @(negedge CLK);
      RST_N = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge CLK);
         #2 chk("t5_rv_drop", {28'b0, res_valid}, 32'h0);
      end
      @(negedge CLK);

      // en low blocks grants
      en    = 1'b0;
      req   = 4'b0101;
      av[0] = 16'd5;
      bv[0] = 16'd5;
      av[2] = 16'd6;
      bv[2] = 16'hFFFA;
      for (int k = 0; k < 3; k++) begin
         #1 chk("t6_gnt", {28'b0, gnt}, 32'h0);
         @(posedge CLK);
         #2 chk("t6_core", {core_a, core_b}, 32'h0);
         @(negedge CLK);
      end
      en = 1'b1;
      #1 chk("t6_resume0", {28'b0, gnt}, 32'h1);
      @(negedge CLK);
      #1 chk("t6_resume1", {28'b0, gnt}, RR ? 32'h4 : 32'h1);
      @(negedge CLK);
      req = '0;
      repeat (8) @(negedge CLK);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
